// File: rtl/tmds_pkg.sv
// Shared constants for the TMDS channel encoder: symbol width, disparity width,
// control-period symbols and a ones-count helper.
package tmds_pkg;

    localparam int unsigned TMDS_W = 10;
    localparam int unsigned CNT_W  = 5;

    localparam logic [TMDS_W-1:0] CTRL_SYM_00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] CTRL_SYM_01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] CTRL_SYM_10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] CTRL_SYM_11 = 10'b1010101011;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_qm.sv
// Combinational transition-minimising stage: 8-bit d -> q_m[8:0] plus ones(q_m[7:0]).
module tmds_qm
    import tmds_pkg::*;
(
    input  logic [7:0] d,
    output logic [8:0] q_m,
    output logic [3:0] n1
);

    logic [3:0] nd;
    logic       use_xnor;
    logic [7:0] chain;

    always_comb begin
        nd       = ones8(d);
        use_xnor = (nd > 4'd4) || ((nd == 4'd4) && !d[0]);
        chain    = '0;
        chain[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            chain[i] = use_xnor ? ~(chain[i-1] ^ d[i]) : (chain[i-1] ^ d[i]);
        end
        q_m = {~use_xnor, chain};
        n1  = ones8(chain);
    end

endmodule

// File: rtl/tmds_chan_encoder.sv
// One TMDS colour channel: BPC-bit colour in, DC-balanced 10-bit symbol out.
// Define TMDS_ENC_PIPE_EN to register q_m/ones count in an extra stage (latency 3 instead of 2).
module tmds_chan_encoder
    import tmds_pkg::*;
#(
    parameter int unsigned BPC = 5
) (
    input  logic              clk_pix,
    input  logic              rst_pix,
    input  logic              de,
    input  logic [BPC-1:0]    din,
    input  logic [1:0]        ctrl,
    output logic [TMDS_W-1:0] dout
);

    logic [7:0] d_exp;
    logic       de_q;
    logic [1:0] ctrl_q;
    logic [7:0] d_q;
    logic [8:0] qm;
    logic [3:0] n1;

    // MSB replication: the input pattern repeats until 8 bits are filled.
    always_comb begin
        d_exp = '0;
        for (int i = 0; i < 8; i++) begin
            d_exp[7-i] = din[BPC-1-(i % BPC)];
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
            d_q    <= '0;
        end else begin
            de_q   <= de;
            ctrl_q <= ctrl;
            d_q    <= d_exp;
        end
    end

    tmds_qm u_qm (
        .d   (d_q),
        .q_m (qm),
        .n1  (n1)
    );

    logic       de_b;
    logic [1:0] ctrl_b;
    logic [8:0] qm_b;
    logic [3:0] n1_b;

`ifdef TMDS_ENC_PIPE_EN
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            de_b   <= 1'b0;
            ctrl_b <= 2'b00;
            qm_b   <= '0;
            n1_b   <= '0;
        end else begin
            de_b   <= de_q;
            ctrl_b <= ctrl_q;
            qm_b   <= qm;
            n1_b   <= n1;
        end
    end
`else
    assign de_b   = de_q;
    assign ctrl_b = ctrl_q;
    assign qm_b   = qm;
    assign n1_b   = n1;
`endif

    logic signed [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMDS_W-1:0]       dout_q, dout_d;
    logic signed [CNT_W:0]   bal, delta, cnt_ext, cnt_sum;

    // One guard bit on the disparity arithmetic; the result always lands in -8..+8.
    always_comb begin
        bal     = $signed({1'b0, n1_b, 1'b0}) - 6'sd8;
        cnt_ext = {cnt_q[CNT_W-1], cnt_q};
        delta   = '0;
        dout_d  = CTRL_SYM_00;
        if (!de_b) begin
            unique case (ctrl_b)
                2'b00:   dout_d = CTRL_SYM_00;
                2'b01:   dout_d = CTRL_SYM_01;
                2'b10:   dout_d = CTRL_SYM_10;
                default: dout_d = CTRL_SYM_11;
            endcase
        end else if ((cnt_q == '0) || (n1_b == 4'd4)) begin
            if (qm_b[8]) begin
                dout_d = {2'b01, qm_b[7:0]};
                delta  = bal;
            end else begin
                dout_d = {2'b10, ~qm_b[7:0]};
                delta  = -bal;
            end
        end else if ((!cnt_q[CNT_W-1] && (n1_b > 4'd4)) || (cnt_q[CNT_W-1] && (n1_b < 4'd4))) begin
            dout_d = {1'b1, qm_b[8], ~qm_b[7:0]};
            delta  = (qm_b[8] ? 6'sd2 : 6'sd0) - bal;
        end else begin
            dout_d = {1'b0, qm_b[8], qm_b[7:0]};
            delta  = (qm_b[8] ? 6'sd0 : -6'sd2) + bal;
        end
        cnt_sum = cnt_ext + delta;
        cnt_d   = de_b ? cnt_sum[CNT_W-1:0] : '0;
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            dout_q <= CTRL_SYM_00;
            cnt_q  <= '0;
        end else begin
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = dout_q;

endmodule
